// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone shared-bus arbiters.
// Build option: define WB_ARB_TIMEOUT_EN to enable the bus-hang watchdog
// and the ABORT state in wb_rr_arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int MAX_MASTERS = 8;

  // Width of a master index / round-robin pointer; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: grants the first requester at an index
// greater than or equal to ptr, wrapping around modulo N. Output is one-hot
// (all zero when nothing requests).
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // Scan from ptr upward with wrap and keep the first hit.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = IW'((int'(ptr) + i) % N);
      if (!found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin grant held
// for the whole CYC burst. Slave termination and read data are routed only
// to the granted master.
// Build option: WB_ARB_TIMEOUT_EN adds a watchdog that aborts a cycle the
// slave never terminates (ERR pulse to the owner, slave CYC/STB forced low).
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = DATA_W / 8
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                          wb_clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_adr_o,
  output logic [SEL_W-1:0]              s_sel_o,
  output logic [DATA_W-1:0]             s_dat_o,
  input  logic [DATA_W-1:0]             s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  output logic [NUM_MASTERS-1:0]        gnt_o
);

  localparam int IW = idx_w(NUM_MASTERS);

  arb_state_e             state_r;
  logic [IW-1:0]          ptr_r;
  logic [IW-1:0]          gnt_idx_r;
  logic [NUM_MASTERS-1:0] gnt_r;
  logic [NUM_MASTERS-1:0] pick_gnt_s;
  logic [IW-1:0]          pick_idx_s;
  logic [IW-1:0]          next_ptr_s;
  logic                   owner_cyc_s;

  wb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr_r),
    .gnt (pick_gnt_s)
  );

  assign gnt_o       = gnt_r;
  assign owner_cyc_s = m_cyc_i[gnt_idx_r];

  // Encode the picker's one-hot winner into an index for the data muxes.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt_s[i]) begin
        pick_idx_s = IW'(i);
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // Pointer after release: owner index + 1, wrapping to 0.
  always_comb begin
    if (gnt_idx_r == IW'(NUM_MASTERS - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_r + IW'(1);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] to_cnt_r;
  logic             err_pulse_r;
  logic             stall_s;
  logic             timeout_hit_s;

  // A stall is a BUSY cycle with STB presented and no termination.
  always_comb begin
    stall_s       = (state_r == BUSY) && s_stb_o && !s_ack_i && !s_err_i;
    timeout_hit_s = stall_s && (to_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Watchdog counter: counts consecutive stall cycles, clears otherwise.
  always_ff @(posedge wb_clk) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (stall_s) begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end
`endif

  // Arbitration FSM: grant in IDLE, hold through the CYC burst, release on CYC low.
  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      gnt_r     <= '0;
      gnt_idx_r <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      err_pulse_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|m_cyc_i) begin
            gnt_r     <= pick_gnt_s;
            gnt_idx_r <= pick_idx_s;
            state_r   <= BUSY;
          end else begin
            gnt_r <= '0;
          end
        end
        BUSY: begin
          if (!owner_cyc_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            ptr_r   <= next_ptr_s;
`ifdef WB_ARB_TIMEOUT_EN
          end else if (timeout_hit_s) begin
            state_r     <= ABORT;
            err_pulse_r <= 1'b1;
`endif
          end else begin
            state_r <= BUSY;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          err_pulse_r <= 1'b0;
          if (!owner_cyc_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            ptr_r   <= next_ptr_s;
          end else begin
            state_r <= ABORT;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
        end
      endcase
    end
  end

  // Route the owner's request to the slave and the slave's response to the owner.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    case (state_r)
      BUSY: begin
        s_cyc_o            = owner_cyc_s;
        s_stb_o            = m_stb_i[gnt_idx_r];
        s_we_o             = m_we_i[gnt_idx_r];
        s_adr_o            = m_adr_i[int'(gnt_idx_r) * ADDR_W +: ADDR_W];
        s_sel_o            = m_sel_i[int'(gnt_idx_r) * SEL_W +: SEL_W];
        s_dat_o            = m_dat_i[int'(gnt_idx_r) * DATA_W +: DATA_W];
        // ERR wins when the slave raises both terminations together.
        m_ack_o[gnt_idx_r] = s_ack_i & ~s_err_i;
        m_err_o[gnt_idx_r] = s_err_i;
        m_dat_o            = s_dat_i;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        m_err_o[gnt_idx_r] = err_pulse_r;
      end
`endif
      default: begin
        m_dat_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed test-plan steps followed by
// randomized traffic, every cycle compared against a behavioural model that
// tracks owner / pointer as plain integers.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_we  = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat = '0;
  logic            s_ack = 1'b0;
  logic            s_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int owner   = -1;
  int ptr     = 0;
  int stall   = 0;
  bit aborted = 1'b0;
  bit pulse   = 1'b0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SEL_W       (SW)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TO)
`endif
  ) dut (
    .wb_clk  (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_sel_i (m_sel),
    .m_dat_i (m_dat),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .gnt_o   (gnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int k, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [SW-1:0] se, input logic [DW-1:0] d);
    m_cyc[k]           = c;
    m_stb[k]           = s;
    m_we[k]            = w;
    m_adr[k*AW +: AW]  = a;
    m_sel[k*SW +: SW]  = se;
    m_dat[k*DW +: DW]  = d;
  endtask

  // Mid-cycle: compare every DUT output with the model's expectation.
  task automatic neg();
    logic [N-1:0]  eg, ea, ee;
    logic          ecyc, estb, ewe;
    logic [AW-1:0] eadr;
    logic [SW-1:0] esel;
    logic [DW-1:0] edat, emdat;
    @(negedge clk);
    eg = '0; ea = '0; ee = '0; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    eadr = '0; esel = '0; edat = '0; emdat = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      if (!aborted) begin
        ecyc      = m_cyc[owner];
        estb      = m_stb[owner];
        ewe       = m_we[owner];
        eadr      = m_adr[owner*AW +: AW];
        esel      = m_sel[owner*SW +: SW];
        edat      = m_dat[owner*DW +: DW];
        ee[owner] = s_err;
        ea[owner] = s_ack & ~s_err;
        emdat     = s_dat;
      end else begin
        ee[owner] = pulse;
      end
    end
    chk("gnt_o", gnt_o, eg);
    chk("s_cyc_o", s_cyc_o, ecyc);
    chk("s_stb_o", s_stb_o, estb);
    chk("s_we_o", s_we_o, ewe);
    chk("s_adr_o", s_adr_o, eadr);
    chk("s_sel_o", s_sel_o, esel);
    chk("s_dat_o", s_dat_o, edat);
    chk("m_ack_o", m_ack_o, ea);
    chk("m_err_o", m_err_o, ee);
    chk("m_dat_o", m_dat_o, emdat);
  endtask

  // Clock edge: advance the model from the inputs the DUT sampled.
  task automatic pos();
    @(posedge clk);
    if (rst) begin
      owner = -1; ptr = 0; stall = 0; aborted = 1'b0; pulse = 1'b0;
    end else if (owner < 0) begin
      for (int j = 0; j < N; j++)
        if (owner < 0 && m_cyc[(ptr + j) % N]) owner = (ptr + j) % N;
    end else if (!m_cyc[owner]) begin
      ptr = (owner + 1) % N; owner = -1; aborted = 1'b0; pulse = 1'b0; stall = 0;
    end
`ifdef WB_ARB_TIMEOUT_EN
    else if (aborted) pulse = 1'b0;
    else if (m_stb[owner] && !s_ack && !s_err) begin
      if (stall == TO - 1) begin aborted = 1'b1; pulse = 1'b1; stall = 0; end
      else stall++;
    end else stall = 0;
`endif
    #1;
  endtask

  task automatic step();
    neg();
    pos();
  endtask

  initial begin
    int found;
    logic [DW-1:0] beat_dat;

    // Reset values
    rst = 1'b1;
    step(); step();
    neg(); chk("rst_gnt", gnt_o, 2'b00); chk("rst_scyc", s_cyc_o, 1'b0); pos();
    rst = 1'b0;

    // T1: single master 0 write, slave ACKs two cycles after STB
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    neg(); chk("t1_idle_cyc", s_cyc_o, 1'b0); pos();
    neg(); chk("t1_adr", s_adr_o, 32'h100); chk("t1_cyc", s_cyc_o, 1'b1);
    chk("t1_wdat", s_dat_o, 32'hDEADBEEF); pos();
    step();
    s_ack = 1'b1;
    neg(); chk("t1_ack", m_ack_o, 2'b01); pos();
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step(); step();

    // T2: contention right after reset, then a repeat contention
    rst = 1'b1; step(); rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 4'h3, 32'h0);
    step();
    neg(); chk("t2_first", gnt_o, 2'b01); pos();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    neg(); chk("t2_gap", gnt_o, 2'b00); pos();
    neg(); chk("t2_second", gnt_o, 2'b10); chk("t2_adr", s_adr_o, 32'h20); pos();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 4'h3, 32'h0);
    step();
    neg(); chk("t2_repeat", gnt_o, 2'b01); pos();

    // T3: master 1 four-beat read burst with an STB gap, master 0 waiting
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    step();
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
        neg(); chk("t3_gap_gnt", gnt_o, 2'b10); chk("t3_gap_stb", s_stb_o, 1'b0); pos();
      end
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * b), 4'hF, 32'h0);
      beat_dat = $urandom;
      s_dat = beat_dat;
      s_ack = 1'b1;
      neg();
      chk("t3_gnt", gnt_o, 2'b10);
      chk("t3_ack", m_ack_o, 2'b10);
      chk("t3_adr", s_adr_o, 32'h200 + 32'(4 * b));
      chk("t3_dat", m_dat_o, beat_dat);
      pos();
      s_ack = 1'b0;
    end
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    neg(); chk("t3_gap", gnt_o, 2'b00); pos();
    neg(); chk("t3_m0", gnt_o, 2'b01); pos();

    // T4: ACK and ERR together on master 0's read
    s_ack = 1'b1; s_err = 1'b1;
    neg(); chk("t4_err", m_err_o, 2'b01); chk("t4_ack", m_ack_o, 2'b00); pos();
    s_ack = 1'b0; s_err = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();

    // T5: reset on beat 2 of a master 0 burst, master 1 also requesting
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
    step();
    for (int b = 0; b < 2; b++) begin
      s_ack = 1'b1; s_dat = $urandom;
      step();
    end
    s_ack = 1'b0;
    rst = 1'b1;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
    step();
    rst = 1'b0;
    neg(); chk("t5_gnt", gnt_o, 2'b00); chk("t5_scyc", s_cyc_o, 1'b0);
    chk("t5_sadr", s_adr_o, 32'h0); pos();
    neg(); chk("t5_regrant", gnt_o, 2'b01); pos();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step(); step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // T6: hung slave, master 1 owns (ptr=1), master 0 waiting
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h700, 4'hF, 32'h0);
    step();
    found = -1;
    for (int k = 0; k < 40 && found < 0; k++) begin
      neg();
      if (m_err_o[1] === 1'b1) found = k;
      pos();
    end
    chk("t6_err_cycle", found, 16);
    neg(); chk("t6_scyc", s_cyc_o, 1'b0); chk("t6_err_once", m_err_o, 2'b00); pos();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step(); step();
    neg(); chk("t6_next", gnt_o, 2'b01); pos();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step(); step();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = 1'($urandom_range(1));
        m_we[k]  = 1'($urandom_range(1));
        m_adr[k*AW +: AW] = $urandom;
        m_sel[k*SW +: SW] = 4'($urandom_range(15));
        m_dat[k*DW +: DW] = $urandom;
      end
      s_ack = 1'($urandom_range(1));
      s_err = ($urandom_range(7) == 0);
      s_dat = $urandom;
      rst   = ($urandom_range(63) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
